// File: rtl/booth_pkg.sv
// Shared constants and FSM state encoding for the signed non-restoring divider.
package booth_pkg;

  localparam int BOOTH_W = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_HI  = 3'd1,
    S_LOAD_LO  = 3'd2,
    S_LOAD_DIV = 3'd3,
    S_RUN      = 3'd4,
    S_FIX      = 3'd5
  } state_t;

endpackage

// File: rtl/nrdiv_step.sv
// One non-restoring division iteration on magnitudes: shift {P,Q}, add/subtract d, emit quotient bit.
module nrdiv_step #(
  parameter int W = 16
) (
  input  logic [W:0]   p,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  output logic [W:0]   p_next,
  output logic [W-1:0] q_next
);

  logic [W:0] p_shift;
  logic [W:0] d_ext;

  assign p_shift = {p[W-1:0], q[W-1]};
  assign d_ext   = {1'b0, d};

  // A negative partial remainder is repaired on the next step instead of restored now.
  assign p_next = p[W] ? (p_shift + d_ext) : (p_shift - d_ext);
  assign q_next = {q[W-2:0], ~p_next[W]};

endmodule

// File: rtl/booth_divider.sv
// Signed 2W/W divider: operands loaded serially on data_in, W non-restoring iterations, sign fix-up.
module booth_divider
  import booth_pkg::*;
#(
  parameter int W = BOOTH_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   data_in,
  output logic [2*W-1:0] result,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
  localparam logic [W-1:0]  Q_POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  Q_NEG_MAX = {1'b1, {(W-1){1'b0}}};

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  hi_reg;
  logic [W-1:0]  lo_reg;
  logic [W:0]    p_reg;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  d_reg;
  logic          qsign_reg;
  logic          rsign_reg;

  logic [2*W-1:0] dividend;
  logic [2*W-1:0] dvd_mag;
  logic           dvd_neg;
  logic [W-1:0]   dvs_mag;
  logic           dvs_neg;
  logic           dvs_zero;
  logic           too_big;

  // Divisor is taken straight off the bus in LOAD_DIV, so its magnitude is formed combinationally.
  assign dividend = {hi_reg, lo_reg};
  assign dvd_neg  = hi_reg[W-1];
  assign dvd_mag  = dvd_neg ? -dividend : dividend;
  assign dvs_neg  = data_in[W-1];
  assign dvs_mag  = dvs_neg ? -data_in : data_in;
  assign dvs_zero = (data_in == '0);
  assign too_big  = (dvd_mag[2*W-1:W] >= dvs_mag);

  logic [W:0]   p_next;
  logic [W-1:0] q_next;

  nrdiv_step #(.W(W)) u_step (
    .p      (p_reg),
    .q      (q_reg),
    .d      (d_reg),
    .p_next (p_next),
    .q_next (q_next)
  );

  logic [W-1:0] r_mag;
  logic [W-1:0] r_val;
  logic [W-1:0] q_val;
  logic         q_ovf;

  // The corrected remainder lies in [0, d), so W-bit wraparound of the add is harmless.
  assign r_mag = p_reg[W] ? (p_reg[W-1:0] + d_reg) : p_reg[W-1:0];
  assign r_val = rsign_reg ? -r_mag : r_mag;
  assign q_val = qsign_reg ? -q_reg : q_reg;
  assign q_ovf = qsign_reg ? (q_reg > Q_NEG_MAX) : (q_reg > Q_POS_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      qsign_reg   <= 1'b0;
      rsign_reg   <= 1'b0;
      result      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_LOAD_HI;
            busy      <= 1'b1;
          end
        end
        S_LOAD_HI: begin
          hi_reg    <= data_in;
          state_reg <= S_LOAD_LO;
        end
        S_LOAD_LO: begin
          lo_reg    <= data_in;
          state_reg <= S_LOAD_DIV;
        end
        S_LOAD_DIV: begin
          qsign_reg <= dvd_neg ^ dvs_neg;
          rsign_reg <= dvd_neg;
          d_reg     <= dvs_mag;
          p_reg     <= {1'b0, dvd_mag[2*W-1:W]};
          q_reg     <= dvd_mag[W-1:0];
          cnt_reg   <= '0;
          if (dvs_zero) begin
            result      <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state_reg   <= S_IDLE;
          end else if (too_big) begin
            // High half already >= divisor means the quotient cannot fit in W bits.
            result      <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state_reg   <= S_IDLE;
          end else begin
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          p_reg   <= p_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_ITER) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          div_by_zero <= 1'b0;
          overflow    <= q_ovf;
          result      <= q_ovf ? '0 : {r_val, q_val};
          done        <= 1'b1;
          busy        <= 1'b0;
          state_reg   <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Randomized scoreboard bench for booth_divider against an integer-arithmetic reference model.
module tb_booth_divider;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   data_in;
  logic [2*W-1:0] result;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic           overflow;

  booth_divider #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_in     (data_in),
    .result      (result),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    logic        ovf;
    int          lat;
    int          start_cyc;
    logic [31:0] dvd;
    logic [15:0] dv;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ops = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed integer division on 64-bit values.
  function automatic exp_t model(input logic [31:0] dvd, input logic [15:0] dv);
    exp_t   e;
    longint a, b, aa, ab, q, r;
    a = longint'($signed(dvd));
    b = longint'($signed(dv));
    e.dvd = dvd;
    e.dv  = dv;
    e.res = '0;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = 20;
    e.start_cyc = 0;
    aa = (a < 0) ? -a : a;
    ab = (b < 0) ? -b : b;
    if (b == 0) begin
      e.dbz = 1'b1;
      e.lat = 3;
    end else if (aa >= (ab << 16)) begin
      e.ovf = 1'b1;
      e.lat = 3;
    end else begin
      q = a / b;
      r = a % b;
      if (q > 32767 || q < -32768) e.ovf = 1'b1;
      else e.res = {r[15:0], q[15:0]};
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no done (result=%h)", result);
        end else begin
          e = sb.pop_front();
          ops++;
          $display("op %0d: %h / %h -> result=%h dbz=%b ovf=%b lat=%0d",
                   ops, e.dvd, e.dv, result, div_by_zero, overflow, cyc - e.start_cyc);
          check("result", result, e.res);
          check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
          check("overflow", 32'(overflow), 32'(e.ovf));
          check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] dvd, input logic [15:0] dv, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    if (push) begin
      e = model(dvd, dv);
      e.start_cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    check("busy_set", 32'(busy), 32'd1);
    start   = 1'b0;
    data_in = dvd[31:16];
    @(negedge clk);
    data_in = dvd[15:0];
    @(negedge clk);
    data_in = dv;
    @(negedge clk);
    data_in = 16'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [31:0] dvd, input logic [15:0] dv);
    issue(dvd, dv, 1'b1);
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [31:0] t;
    logic [31:0] dvd;
    logic [15:0] dv;
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(32'h0000_0082, 16'h000A);
    run_op(32'hFFFF_FF7D, 16'h000A);
    run_op(32'h1234_5678, 16'h0000);
    run_op(32'hFFFF_8000, 16'h0001);
    run_op(32'hFFFF_8000, 16'hFFFF);
    run_op(32'h7FFF_0000, 16'h0001);
    run_op(32'd130, 16'd13);
    run_op(32'h8000_0000, 16'h8000);
    run_op(32'h0000_7FFF, 16'h8000);

    // start pulsed during RUN must be ignored
    issue(32'h0012_3456, 16'h1357, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    // reset during RUN: outputs clear, no done, next op completes
    issue(32'h0000_1000, 16'h0007, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    run_op(32'hFFFF_FC00, 16'h0020);

    for (int i = 0; i < 60; i++) begin
      t = $urandom;
      case ($urandom_range(0, 2))
        0: dvd = t;
        1: dvd = {{8{t[23]}}, t[23:0]};
        default: dvd = {{16{t[15]}}, t[15:0]};
      endcase
      case ($urandom_range(0, 7))
        0: dv = 16'h0000;
        1: dv = 16'h0001;
        2: dv = 16'hFFFF;
        3: dv = 16'h8000;
        default: begin
          dv = 16'($urandom);
          if ($urandom_range(0, 1) == 1) dv = $signed(dv) >>> $urandom_range(0, 13);
        end
      endcase
      run_op(dvd, dv);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
